pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder.sv | 164 ++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-wide lookahead slice per stage,
// carries rippling stage to stage, unconsumed operand bits skewed forward, sum bits de-skewed.
module cla_block #(
  parameter int BLOCK = 16
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout
);
  localparam int NG = BLOCK / 4;

  logic [BLOCK-1:0] p, g;
  logic [BLOCK:0]   c;
  logic [NG:0]      cg;
  logic [NG-1:0]    gg, gp;

  assign p = a ^ b;
  assign g = a & b;

  // Group generate/propagate first, then group carries, then bit carries inside each group.
  always_comb begin
    gg = '0;
    gp = '0;
    cg = '0;
    c  = '0;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    cg[0] = cin;
    for (int j = 0; j < NG; j++) cg[j+1] = gg[j] | (gp[j] & cg[j]);
    for (int j = 0; j < NG; j++) begin
      c[4*j] = cg[j];
      for (int i = 0; i < 3; i++) c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
    end
    c[BLOCK] = cg[NG];
  end

  assign s    = p ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];
endmodule

module pipelined_cla_adder #(
  parameter int WIDTH = 64,
  parameter int BLOCK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int N = WIDTH / BLOCK;

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [N-1:0]     vld_pipe;
  logic [N-1:0]     adv;

  assign b_eff = b ^ {WIDTH{sub}};
  assign c0    = cin ^ sub;

  // A stage moves when it is empty or its successor moves; the chain starts at out_ready.
  always_comb begin
    logic go;
    adv = '0;
    go  = out_ready;
    for (int k = N-1; k >= 0; k--) begin
      go     = ~vld_pipe[k] | go;
      adv[k] = go;
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < N; k++) begin : stg
    localparam int SW = WIDTH - k*BLOCK;
    localparam int LW = (k+1)*BLOCK;

    logic [SW-1:0]    src_a, src_b;
    logic             src_c, v_in, vld, blk_co, c_r;
    logic [BLOCK-1:0] blk_s;
    logic [LW-1:0]    s_nxt, s_r;

    if (k == 0) begin : src
      assign src_a = a;
      assign src_b = b_eff;
      assign src_c = c0;
      assign v_in  = in_valid;
      assign s_nxt = blk_s;
    end else begin : src
      assign src_a = stg[k-1].upr.a_r;
      assign src_b = stg[k-1].upr.b_r;
      assign src_c = stg[k-1].c_r;
      assign v_in  = stg[k-1].vld;
      assign s_nxt = {blk_s, stg[k-1].s_r};
    end

    cla_block #(.BLOCK(BLOCK)) u_blk (
      .a    (src_a[BLOCK-1:0]),
      .b    (src_b[BLOCK-1:0]),
      .cin  (src_c),
      .s    (blk_s),
      .cout (blk_co)
    );

    assign vld_pipe[k] = vld;

    if (k < N-1) begin : upr
      logic [SW-BLOCK-1:0] a_r, b_r;

      always_ff @(posedge clk) begin
        if (rst)         vld <= 1'b0;
        else if (adv[k]) vld <= v_in;
      end

      always_ff @(posedge clk) begin
        if (adv[k]) begin
          a_r <= src_a[SW-1:BLOCK];
          b_r <= src_b[SW-1:BLOCK];
          s_r <= s_nxt;
          c_r <= blk_co;
        end
      end
    end else begin : fin
      logic ovf_r, zero_r;

      // Carry into the MSB recovered as s ^ a ^ b at that bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld    <= 1'b0;
          s_r    <= '0;
          c_r    <= 1'b0;
          ovf_r  <= 1'b0;
          zero_r <= 1'b0;
        end else if (adv[k]) begin
          vld    <= v_in;
          s_r    <= s_nxt;
          c_r    <= blk_co;
          ovf_r  <= blk_co ^ blk_s[BLOCK-1] ^ src_a[BLOCK-1] ^ src_b[BLOCK-1];
          zero_r <= ~|s_nxt;
        end
      end

      assign out_valid = vld;
      assign sum       = s_r;
      assign cout      = c_r;
      assign ovf       = ovf_r;
      assign zero      = zero_r;
    end
  end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed table plus stream, stall and reset sequences on
// the 64/16 build, and a randomized handshake run on a 32/8 build against a reference model.
module tb_pipelined_cla_adder;
  localparam int N  = 4;
  localparam int N2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [63:0] a, b, sum;
  logic        rst2, in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2, zero2;
  logic [31:0] a2, b2, sum2;

  pipelined_cla_adder #(.WIDTH(64), .BLOCK(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero));

  pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) dut32 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .cin(cin2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2),
    .cout(cout2), .ovf(ovf2), .zero(zero2));

  typedef struct {
    logic [63:0] a, b;
    logic        cin, sub;
    logic [63:0] sum;
    logic        cout, ovf, zero;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic        cout, ovf, zero;
    int          tk;
  } exp_t;

  int n_chk = 0, n_fail = 0;
  int tick_no = 0, n_acc = 0, n_take = 0, first_take = -1, last_take = -1, n_spur = 0;
  bit chk_lat = 1'b0, was_stall = 1'b0, done2 = 1'b0;
  exp_t cur_exp, q[$];
  logic [63:0] held_sum;
  logic        held_cout, held_ovf, held_zero;
  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Independent model: wide add, overflow from operand/result sign agreement.
  function automatic exp_t ref_op(input int w, input logic [63:0] xa, input logic [63:0] xb,
                                  input logic xc, input logic xs);
    exp_t        e;
    logic [63:0] mask, be, s;
    logic [64:0] t;
    mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    be     = (xs ? ~xb : xb) & mask;
    t      = {1'b0, xa & mask} + {1'b0, be} + 65'(xc ^ xs);
    s      = t[63:0] & mask;
    e.sum  = s;
    e.cout = t[w];
    e.ovf  = (xa[w-1] == be[w-1]) && (s[w-1] != xa[w-1]);
    e.zero = (s == 64'd0);
    e.tk   = 0;
    return e;
  endfunction

  task automatic clr_phase();
    n_acc = 0; n_take = 0; first_take = -1; last_take = -1;
  endtask

  // Called right after a falling edge once inputs are set; samples before the rising edge.
  task automatic tick();
    exp_t e;
    #1;
    if (!rst) begin
      if (out_valid && !out_ready) begin
        if (was_stall) begin
          chk("stall_sum",  held_sum, sum);
          chk("stall_cout", 64'(held_cout), 64'(cout));
          chk("stall_ovf",  64'(held_ovf), 64'(ovf));
          chk("stall_zero", 64'(held_zero), 64'(zero));
        end
        was_stall = 1'b1;
        held_sum = sum; held_cout = cout; held_ovf = ovf; held_zero = zero;
      end else was_stall = 1'b0;
      if (out_valid && out_ready) begin
        n_take++;
        if (first_take < 0) first_take = tick_no;
        last_take = tick_no;
        if (q.size() == 0) begin
          n_spur++;
        end else begin
          e = q.pop_front();
          chk("sum",  sum, e.sum);
          chk("cout", 64'(cout), 64'(e.cout));
          chk("ovf",  64'(ovf), 64'(e.ovf));
          chk("zero", 64'(zero), 64'(e.zero));
          if (chk_lat) chk("latency", 64'(tick_no - e.tk), 64'(N));
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        e = cur_exp;
        e.tk = tick_no;
        q.push_back(e);
      end
    end
    @(negedge clk);
    tick_no++;
  endtask

  task automatic drive_rand64();
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    cin = 1'($urandom);
    sub = 1'($urandom);
    cur_exp = ref_op(64, a, b, cin, sub);
  endtask

  initial begin
    vt[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{64'd5, 64'd5, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vt[6]  = '{64'h0000_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd6, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
               64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
    vt[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vt[11] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    cur_exp = ref_op(64, 64'd0, 64'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready), 64'd1);
    chk("rst_sum",       sum, 64'd0);
    chk("rst_flags",     64'({cout, ovf, zero}), 64'd0);
    rst = 1'b0;

    // Directed table, one operation at a time, exact latency checked.
    chk_lat = 1'b1;
    foreach (vt[i]) begin
      clr_phase();
      a = vt[i].a; b = vt[i].b; cin = vt[i].cin; sub = vt[i].sub; in_valid = 1'b1;
      cur_exp = '{vt[i].sum, vt[i].cout, vt[i].ovf, vt[i].zero, 0};
      tick();
      in_valid = 1'b0;
      repeat (N + 1) tick();
      chk("table_results", 64'(n_take), 64'd1);
    end

    // Back-to-back stream of 8.
    clr_phase();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin drive_rand64(); tick(); end
    in_valid = 1'b0;
    repeat (N + 2) tick();
    chk("stream_count", 64'(n_take), 64'd8);
    chk("stream_consecutive", 64'(last_take - first_take), 64'd7);

    // Fill with out_ready low, stall 6 cycles while in_valid stays high, then drain.
    clr_phase();
    chk_lat = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < N + 6; i++) begin drive_rand64(); tick(); end
    chk("stall_accepts", 64'(n_acc), 64'(N));
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (N + 2) tick();
    chk("drain_count", 64'(n_take), 64'(N));
    chk("drain_queue", 64'(q.size()), 64'd0);

    // Reset with three in flight; in_valid held high during reset.
    clr_phase();
    chk_lat = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin drive_rand64(); tick(); end
    rst = 1'b1; drive_rand64();
    tick();
    q.delete();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready",  64'(in_ready), 64'd1);
    chk("mid_rst_sum",       sum, 64'd0);
    repeat (8) tick();
    a = 64'd100; b = 64'd23; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    cur_exp = '{64'd77, 1'b1, 1'b0, 1'b0, 0};
    tick();
    in_valid = 1'b0;
    repeat (N + 1) tick();
    chk("post_rst_results", 64'(n_take), 64'd1);
    chk("spurious_outputs", 64'(n_spur), 64'd0);

    for (int i = 0; i < 2000 && !done2; i++) @(negedge clk);
    chk("dut32_finished", 64'(done2), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // 32/8 build: random valid/ready handshaking against the model.
  initial begin
    exp_t q2[$];
    exp_t e2, pend2;
    int   acc2 = 0, take2 = 0;
    logic [31:0] corner[4];
    corner[0] = 32'h7FFF_FFFF; corner[1] = 32'h8000_0000;
    corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h0000_0000;
    rst2 = 1'b1; in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b1;
    pend2 = ref_op(32, 64'd0, 64'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_valid2  = ($urandom_range(3) != 0);
      out_ready2 = ($urandom_range(2) != 0);
      a2   = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
      b2   = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
      cin2 = 1'($urandom);
      sub2 = 1'($urandom);
      pend2 = ref_op(32, {32'd0, a2}, {32'd0, b2}, cin2, sub2);
      if (i > 290) begin in_valid2 = 1'b0; out_ready2 = 1'b1; end
      #1;
      if (out_valid2 && out_ready2) begin
        take2++;
        if (q2.size() == 0) n_spur++;
        else begin
          e2 = q2.pop_front();
          chk("w32_sum",  64'(sum2), e2.sum);
          chk("w32_cout", 64'(cout2), 64'(e2.cout));
          chk("w32_ovf",  64'(ovf2), 64'(e2.ovf));
          chk("w32_zero", 64'(zero2), 64'(e2.zero));
        end
      end
      if (in_valid2 && in_ready2) begin acc2++; q2.push_back(pend2); end
      @(negedge clk);
    end
    chk("w32_all_drained", 64'(take2), 64'(acc2));
    chk("w32_queue", 64'(q2.size()), 64'd0);
    done2 = 1'b1;
  end
endmodule
